ram_arbiter: RTL and testbench

- Shares the single RAM port between the icache and dcache of each of CPUS cores.
- Sits between the per-core caches and the memory model, beneath the bus/coherence controller's memory side.
- Dcache traffic is a locked 2-word block (two beats): block load, or dirty-block writeback.
- Icache traffic is a single-word read.

---
 rtl/ram_arbiter_pkg.sv | 13 +
 rtl/ram_arb_select.sv | 47 ++++
 rtl/ram_arbiter.sv | 150 +++++++++++++++
 tb/tb_ram_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the per-core icache/dcache RAM port arbiter.
package ram_arbiter_pkg;

  localparam int unsigned WordW = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IWORD,
    ARB_DWORD1,
    ARB_DWORD2
  } arb_state_t;

endpackage

// File: rtl/ram_arb_select.sv
// Fixed-order request picker: d(rr), d(~rr), i(rr), i(~rr).
module ram_arb_select #(
  parameter int unsigned CPUS = 2
) (
  input  logic [CPUS-1:0] iREN,
  input  logic [CPUS-1:0] dREN,
  input  logic [CPUS-1:0] dWEN,
  input  logic            rr,
  output logic            valid,
  output logic            core,
  output logic            is_d
);

  logic [1:0] ireq;
  logic [1:0] dreq;

  // Pad to two cores so the ~rr lookup stays in range when CPUS = 1.
  always_comb begin
    ireq = '0;
    dreq = '0;
    for (int c = 0; c < int'(CPUS); c++) begin
      ireq[c] = iREN[c];
      dreq[c] = dREN[c] | dWEN[c];
    end
  end

  always_comb begin
    valid = 1'b1;
    is_d  = 1'b1;
    core  = rr;
    if (dreq[rr]) begin
      core = rr;
    end else if (dreq[~rr]) begin
      core = ~rr;
    end else if (ireq[rr]) begin
      is_d = 1'b0;
      core = rr;
    end else if (ireq[~rr]) begin
      is_d = 1'b0;
      core = ~rr;
    end else begin
      valid = 1'b0;
      is_d  = 1'b0;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between each core's icache (1 word) and dcache (locked 2-beat block).
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned CPUS = 2
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [CPUS-1:0]             iREN,
  input  logic [CPUS-1:0][WordW-1:0]  iaddr,
  output logic [CPUS-1:0]             iwait,
  output logic [WordW-1:0]            iload,
  input  logic [CPUS-1:0]             dREN,
  input  logic [CPUS-1:0]             dWEN,
  input  logic [CPUS-1:0][WordW-1:0]  daddr,
  input  logic [CPUS-1:0][WordW-1:0]  dstore,
  output logic [CPUS-1:0]             dwait,
  output logic [WordW-1:0]            dload,
  output logic                        ramREN,
  output logic                        ramWEN,
  output logic [WordW-1:0]            ramaddr,
  output logic [WordW-1:0]            ramstore,
  input  logic [WordW-1:0]            ramload,
  input  logic                        ram_ready
);

  arb_state_t state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       rr_q, rr_d;

  logic sel_valid, sel_core, sel_is_d;

  logic [1:0]             ireq, dren_p, dwen_p, dreq;
  logic [1:0][WordW-1:0]  iaddr_p, daddr_p, dstore_p;
  logic [1:0]             iwait_p, dwait_p;

  // Two-core padded views keep the 1-bit grant index in range for any CPUS.
  always_comb begin
    ireq     = '0;
    dren_p   = '0;
    dwen_p   = '0;
    iaddr_p  = '0;
    daddr_p  = '0;
    dstore_p = '0;
    for (int c = 0; c < int'(CPUS); c++) begin
      ireq[c]     = iREN[c];
      dren_p[c]   = dREN[c];
      dwen_p[c]   = dWEN[c];
      iaddr_p[c]  = iaddr[c];
      daddr_p[c]  = daddr[c];
      dstore_p[c] = dstore[c];
    end
  end

  assign dreq = dren_p | dwen_p;

  ram_arb_select #(
    .CPUS (CPUS)
  ) u_select (
    .iREN  (iREN),
    .dREN  (dREN),
    .dWEN  (dWEN),
    .rr    (rr_q),
    .valid (sel_valid),
    .core  (sel_core),
    .is_d  (sel_is_d)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ARB_IDLE;
      gnt_q   <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    case (state_q)
      ARB_IDLE: begin
        if (sel_valid) begin
          gnt_d   = sel_core;
          state_d = sel_is_d ? ARB_DWORD1 : ARB_IWORD;
        end
      end
      ARB_IWORD: begin
        if (!ireq[gnt_q]) begin
          state_d = ARB_IDLE;
        end else if (ram_ready) begin
          state_d = ARB_IDLE;
          rr_d    = ~gnt_q;
        end
      end
      ARB_DWORD1: begin
        if (!dreq[gnt_q]) begin
          state_d = ARB_IDLE;
        end else if (ram_ready) begin
          state_d = ARB_DWORD2;
        end
      end
      ARB_DWORD2: begin
        if (!dreq[gnt_q]) begin
          state_d = ARB_IDLE;
        end else if (ram_ready) begin
          state_d = ARB_IDLE;
          rr_d    = ~gnt_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (CPUS == 1) rr_d = 1'b0;
  end

  // Strobes follow the live request so a dropped request aborts without a wait pulse.
  always_comb begin
    iwait_p  = '1;
    dwait_p  = '1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_q)
      ARB_IWORD: begin
        ramREN         = ireq[gnt_q];
        ramaddr        = iaddr_p[gnt_q];
        iwait_p[gnt_q] = ~(ireq[gnt_q] & ram_ready);
      end
      ARB_DWORD1, ARB_DWORD2: begin
        ramWEN         = dwen_p[gnt_q];
        ramREN         = dren_p[gnt_q] & ~dwen_p[gnt_q];
        ramaddr        = daddr_p[gnt_q];
        ramstore       = dstore_p[gnt_q];
        dwait_p[gnt_q] = ~(dreq[gnt_q] & ram_ready);
      end
      default: ;
    endcase
  end

  assign iwait = iwait_p[CPUS-1:0];
  assign dwait = dwait_p[CPUS-1:0];
  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: every wait pulse is matched against the expected service order.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic              CLK = 1'b0;
  logic              nRST;
  logic [1:0]        iREN, dREN, dWEN;
  logic [1:0][31:0]  iaddr, daddr, dstore;
  logic [1:0]        iwait, dwait;
  logic [31:0]       iload, dload, ramaddr, ramstore, ramload, fixed_load;
  logic              ramREN, ramWEN, ram_ready, use_fixed;

  typedef struct packed {
    logic        is_d;
    logic        core;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  ram_arbiter #(
    .CPUS (2)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .dwait     (dwait),
    .dload     (dload),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramload   (ramload),
    .ram_ready (ram_ready)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic ev_t mk(input logic is_d, input logic core, input logic [31:0] a,
                             input logic [31:0] d);
    ev_t e;
    e.is_d = is_d;
    e.core = core;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  always_comb ramload = use_fixed ? fixed_load : mem_word(ramaddr);

  // Monitor: invariants every cycle, and each wait pulse popped against the scoreboard.
  always @(negedge CLK) begin
    ev_t  o, e;
    logic low;
    if (nRST === 1'b1) begin
      checks++;
      if ($countones({~iwait, ~dwait}) > 1) begin
        failures++;
        $display("FAIL one_wait_low: iwait=%b dwait=%b, required at most one low", iwait, dwait);
      end
      checks++;
      if (ramREN && ramWEN) begin
        failures++;
        $display("FAIL strobe_excl: ramREN=%b ramWEN=%b, required not both", ramREN, ramWEN);
      end
      for (int k = 0; k < 4; k++) begin
        o.is_d = (k >= 2);
        o.core = (k % 2 == 1);
        low    = o.is_d ? !dwait[o.core] : !iwait[o.core];
        if (low) begin
          o.addr = ramaddr;
          o.data = o.is_d ? (ramWEN ? ramstore : dload) : iload;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: got is_d=%0d core=%0d addr=%h data=%h, required none",
                     o.is_d, o.core, o.addr, o.data);
          end else begin
            e = exp_q.pop_front();
            if (o !== e) begin
              failures++;
              $display("FAIL sb_event: got is_d=%0d core=%0d addr=%h data=%h, required is_d=%0d core=%0d addr=%h data=%h",
                       o.is_d, o.core, o.addr, o.data, e.is_d, e.core, e.addr, e.data);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_pulse(input logic is_d, input int core, input int budget,
                            output logic seen);
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge CLK);
      seen = is_d ? !dwait[core] : !iwait[core];
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ram_ready = 1'b0; use_fixed = 1'b0; fixed_load = '0;
    #2;
    checks++;
    if ({iwait, dwait} !== 4'hF) begin
      failures++; $display("FAIL rst_waits: got %b required 1111", {iwait, dwait});
    end
    checks++;
    if ({ramREN, ramWEN} !== 2'b00) begin
      failures++; $display("FAIL rst_strobes: got %b required 00", {ramREN, ramWEN});
    end
    checks++;
    if (ramaddr !== 32'h0) begin
      failures++; $display("FAIL rst_addr: got %h required 0", ramaddr);
    end
    checks++;
    if (ramstore !== 32'h0) begin
      failures++; $display("FAIL rst_store: got %h required 0", ramstore);
    end
    checks++;
    if (iload !== mem_word(32'h0)) begin
      failures++; $display("FAIL rst_iload: got %h required %h", iload, mem_word(32'h0));
    end
    checks++;
    if (dload !== mem_word(32'h0)) begin
      failures++; $display("FAIL rst_dload: got %h required %h", dload, mem_word(32'h0));
    end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_single_icache();
    tick();
    use_fixed = 1'b1; fixed_load = 32'hDEAD_BEEF; ram_ready = 1'b1;
    iREN[0] = 1'b1; iaddr[0] = 32'h100;
    exp_q.push_back(mk(1'b0, 1'b0, 32'h100, 32'hDEAD_BEEF));
    @(negedge CLK);
    checks++;
    if ({ramREN, iwait} !== 3'b011) begin
      failures++; $display("FAIL ic_cycle_n: got ramREN,iwait=%b required 011", {ramREN, iwait});
    end
    @(negedge CLK);
    checks++;
    if ({ramREN, ramaddr, iwait} !== {1'b1, 32'h100, 2'b10}) begin
      failures++;
      $display("FAIL ic_serve: got ramREN=%b addr=%h iwait=%b required 1 00000100 10",
               ramREN, ramaddr, iwait);
    end
    tick();
    iREN[0] = 1'b0;
    @(negedge CLK);
    checks++;
    if ({ramREN, iwait} !== 3'b011) begin
      failures++; $display("FAIL ic_idle: got ramREN,iwait=%b required 011", {ramREN, iwait});
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL ic_sb_left: got %0d pending required 0", exp_q.size());
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_dcache_writeback();
    logic [31:0] a, d;
    tick();
    ram_ready = 1'b0;
    dWEN[1] = 1'b1; daddr[1] = 32'h200; dstore[1] = 32'h1111_1111;
    iREN[0] = 1'b1; iaddr[0] = 32'h300;
    exp_q.push_back(mk(1'b1, 1'b1, 32'h200, 32'h1111_1111));
    exp_q.push_back(mk(1'b1, 1'b1, 32'h204, 32'h2222_2222));
    tick();
    for (int b = 0; b < 2; b++) begin
      a = (b == 0) ? 32'h200 : 32'h204;
      d = (b == 0) ? 32'h1111_1111 : 32'h2222_2222;
      repeat (2) begin
        @(negedge CLK);
        checks++;
        if ({ramWEN, ramREN, ramaddr, ramstore, iwait, dwait} !== {2'b10, a, d, 4'hF}) begin
          failures++;
          $display("FAIL wb_hold%0d: got wen=%b ren=%b addr=%h store=%h iwait=%b dwait=%b required 1 0 %h %h 11 11",
                   b, ramWEN, ramREN, ramaddr, ramstore, iwait, dwait, a, d);
        end
        tick();
      end
      ram_ready = 1'b1;
      @(negedge CLK);
      checks++;
      if ({dwait, iwait} !== 4'b0111) begin
        failures++; $display("FAIL wb_pulse%0d: got dwait,iwait=%b required 0111", b, {dwait, iwait});
      end
      tick();
      ram_ready = 1'b0;
      if (b == 0) begin
        daddr[1] = 32'h204; dstore[1] = 32'h2222_2222;
      end else begin
        dWEN[1] = 1'b0; iREN[0] = 1'b0;
      end
    end
    @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL wb_sb_left: got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_priority();
    logic seen;
    tick();
    ram_ready = 1'b1;
    iREN = 2'b11; iaddr[0] = 32'h400; iaddr[1] = 32'h500;
    dREN[1] = 1'b1; daddr[1] = 32'h600;
    exp_q.push_back(mk(1'b1, 1'b1, 32'h600, mem_word(32'h600)));
    exp_q.push_back(mk(1'b1, 1'b1, 32'h604, mem_word(32'h604)));
    exp_q.push_back(mk(1'b0, 1'b0, 32'h400, mem_word(32'h400)));
    exp_q.push_back(mk(1'b0, 1'b1, 32'h500, mem_word(32'h500)));
    wait_pulse(1'b1, 1, 4, seen);
    checks++;
    if (!seen) begin failures++; $display("FAIL prio_d1_b1: got no pulse required dwait[1] low"); end
    tick();
    daddr[1] = 32'h604;
    wait_pulse(1'b1, 1, 3, seen);
    checks++;
    if (!seen) begin failures++; $display("FAIL prio_d1_b2: got no pulse required dwait[1] low"); end
    tick();
    dREN[1] = 1'b0;
    wait_pulse(1'b0, 0, 4, seen);
    checks++;
    if (!seen) begin failures++; $display("FAIL prio_i0: got no pulse required iwait[0] low"); end
    tick();
    iREN[0] = 1'b0;
    wait_pulse(1'b0, 1, 4, seen);
    checks++;
    if (!seen) begin failures++; $display("FAIL prio_i1: got no pulse required iwait[1] low"); end
    tick();
    iREN[1] = 1'b0;
    @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL prio_sb_left: got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_fairness();
    logic [31:0] nxt [2];
    logic        seen;
    int          c;
    tick();
    ram_ready = 1'b1;
    dREN = 2'b11; daddr[0] = 32'h1000; daddr[1] = 32'h2000;
    nxt[0] = 32'h1000; nxt[1] = 32'h2000;
    for (int b = 0; b < 4; b++) begin
      c = b % 2;
      exp_q.push_back(mk(1'b1, c[0], nxt[c], mem_word(nxt[c])));
      exp_q.push_back(mk(1'b1, c[0], nxt[c] + 32'd4, mem_word(nxt[c] + 32'd4)));
      nxt[c] = nxt[c] + 32'd8;
    end
    for (int p = 0; p < 8; p++) begin
      seen = 1'b0;
      for (int k = 0; k < 6 && !seen; k++) begin
        @(negedge CLK);
        seen = (dwait != 2'b11);
      end
      checks++;
      if (!seen) begin
        failures++; $display("FAIL fair_pulse%0d: got no dwait pulse required one", p);
      end
      c = dwait[0] ? 1 : 0;
      tick();
      daddr[c] = daddr[c] + 32'd4;
    end
    dREN = 2'b00;
    @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL fair_sb_left: got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_abort();
    logic seen;
    tick();
    ram_ready = 1'b1;
    dREN[0] = 1'b1; daddr[0] = 32'h3000;
    exp_q.push_back(mk(1'b1, 1'b0, 32'h3000, mem_word(32'h3000)));
    wait_pulse(1'b1, 0, 4, seen);
    checks++;
    if (!seen) begin failures++; $display("FAIL abort_b1: got no pulse required dwait[0] low"); end
    tick();
    ram_ready = 1'b0; daddr[0] = 32'h3004;
    @(negedge CLK);
    checks++;
    if ({ramREN, ramaddr, dwait} !== {1'b1, 32'h3004, 2'b11}) begin
      failures++;
      $display("FAIL abort_hold: got ren=%b addr=%h dwait=%b required 1 00003004 11",
               ramREN, ramaddr, dwait);
    end
    tick();
    dREN[0] = 1'b0;
    @(negedge CLK);
    checks++;
    if ({ramREN, ramWEN, dwait} !== 4'b0011) begin
      failures++; $display("FAIL abort_drop: got ren,wen,dwait=%b required 0011", {ramREN, ramWEN, dwait});
    end
    tick();
    @(negedge CLK);
    checks++;
    if ({ramREN, ramaddr} !== {1'b0, 32'h0}) begin
      failures++; $display("FAIL abort_idle: got ren=%b addr=%h required 0 00000000", ramREN, ramaddr);
    end
    // rr must still favour core 0 after the abort.
    tick();
    ram_ready = 1'b1;
    dREN = 2'b11; daddr[0] = 32'h3100; daddr[1] = 32'h3200;
    exp_q.push_back(mk(1'b1, 1'b0, 32'h3100, mem_word(32'h3100)));
    wait_pulse(1'b1, 0, 4, seen);
    checks++;
    if (!seen) begin failures++; $display("FAIL abort_rr: got no pulse required dwait[0] low"); end
    tick();
    dREN = 2'b00;
    @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL abort_sb_left: got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    tick();
    ram_ready = 1'b1;
    iREN[0] = 1'b1; iaddr[0] = 32'h700;
    exp_q.push_back(mk(1'b0, 1'b0, 32'h700, mem_word(32'h700)));
    wait_pulse(1'b0, 0, 4, seen);
    checks++;
    if (!seen) begin failures++; $display("FAIL rstm_i0: got no pulse required iwait[0] low"); end
    tick();
    iREN[0] = 1'b0; ram_ready = 1'b0;
    dREN[1] = 1'b1; daddr[1] = 32'h5000;
    tick();
    @(negedge CLK);
    checks++;
    if ({ramREN, ramaddr} !== {1'b1, 32'h5000}) begin
      failures++; $display("FAIL rstm_pre: got ren=%b addr=%h required 1 00005000", ramREN, ramaddr);
    end
    #2;
    nRST = 1'b0;
    #1;
    checks++;
    if ({ramREN, ramWEN, iwait, dwait, ramaddr} !== {2'b00, 4'hF, 32'h0}) begin
      failures++;
      $display("FAIL rstm_async: got ren=%b wen=%b iwait=%b dwait=%b addr=%h required 0 0 11 11 0",
               ramREN, ramWEN, iwait, dwait, ramaddr);
    end
    dREN = 2'b11; daddr[0] = 32'h6000; ram_ready = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b0, 32'h6000, mem_word(32'h6000)));
    #1;
    nRST = 1'b1;
    wait_pulse(1'b1, 0, 4, seen);
    checks++;
    if (!seen) begin failures++; $display("FAIL rstm_rr0: got no pulse required dwait[0] low"); end
    tick();
    dREN = 2'b00;
    @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL rstm_sb_left: got %0d pending required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_icache();
    test_dcache_writeback();
    test_priority();
    test_fairness();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish before 200000");
    $fatal(1);
  end

endmodule
